// File: rtl/pulpemu_stdout_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : pulpemu_stdout_buffer
// Brief  : PULP stdout byte buffer handed to the Zynq host via a 4-phase
//          stdout_wait / stdout_flushed handshake. Optional line-buffered
//          mode with macro PULPEMU_STDOUT_NEWLINE_FLUSH_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module pulpemu_stdout_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid_i,
  input  logic [7:0]                 wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       flush_req_i,
  output logic                       stdout_wait_o,
  input  logic                       stdout_flushed_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [7:0]                 rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  logic [AW:0] r_count;
  logic        r_wait;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_mem [DEPTH];

  logic        w_accept;
  logic [AW:0] w_count_next;
  logic        w_flush;

  assign wr_ready_o    = (r_state == FILL);
  assign w_accept      = wr_valid_i && wr_ready_o;
  assign w_count_next  = r_count + (AW+1)'(w_accept);

`ifdef PULPEMU_STDOUT_NEWLINE_FLUSH_EN
  assign w_flush = flush_req_i || (w_accept && (wr_data_i == 8'h0A));
`else
  assign w_flush = flush_req_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_count <= '0;
      r_wait  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_count <= w_count_next;
          // A flush with nothing stored (and nothing arriving) is dropped.
          if ((w_accept && (w_count_next == c_full)) ||
              (w_flush && (w_count_next != '0))) begin
            r_state <= WAIT;
            r_wait  <= 1'b1;
          end
        end
        WAIT: begin
          if (stdout_flushed_i) begin
            r_state <= RELEASE;
            r_count <= '0;
            r_wait  <= 1'b0;
          end
        end
        RELEASE: begin
          // Acknowledge must drop before the next batch can start.
          if (!stdout_flushed_i) begin
            r_state <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
          r_count <= '0;
          r_wait  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_mem[r_count[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign stdout_wait_o = r_wait;
  assign rd_data_o     = r_rd_data;
  assign level_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_stdout_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_pulpemu_stdout_buffer
// Brief  : Directed + randomized self-checking bench against a buffer model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pulpemu_stdout_buffer;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic          flush_req = 1'b0;
  logic          stdout_wait;
  logic          stdout_flushed = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [AW:0]   level;

  int total = 0;
  int bad   = 0;

  // Reference model: a byte array, a fill count, and two flags describing
  // who owns the buffer (host holds it / host still acknowledging).
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  int         m_cnt = 0;
  bit         m_host_owns = 0;
  bit         m_ack_pending = 0;

  pulpemu_stdout_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_valid_i       (wr_valid),
    .wr_data_i        (wr_data),
    .wr_ready_o       (wr_ready),
    .flush_req_i      (flush_req),
    .stdout_wait_o    (stdout_wait),
    .stdout_flushed_i (stdout_flushed),
    .rd_addr_i        (rd_addr),
    .rd_data_o        (rd_data),
    .level_o          (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return !m_host_owns && !m_ack_pending;
  endfunction

  function automatic bit is_trigger_byte(input logic [7:0] b);
`ifdef PULPEMU_STDOUT_NEWLINE_FLUSH_EN
    return b == 8'h0A;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick();
    bit         rd_chk;
    logic [7:0] rd_exp;
    bit         acc;
    rd_chk = m_known[rd_addr];
    rd_exp = m_mem[rd_addr];
    acc    = wr_valid && model_ready();
    if (m_host_owns) begin
      if (stdout_flushed) begin
        m_host_owns   = 0;
        m_ack_pending = 1;
        m_cnt         = 0;
      end
    end else if (m_ack_pending) begin
      if (!stdout_flushed) m_ack_pending = 0;
    end else begin
      if (acc) begin
        m_mem[m_cnt]   = wr_data;
        m_known[m_cnt] = 1;
        m_cnt++;
      end
      if (m_cnt == DEPTH ||
          ((flush_req || (acc && is_trigger_byte(wr_data))) && m_cnt > 0))
        m_host_owns = 1;
    end
    @(posedge clk);
    #1;
    check("wr_ready", 32'(wr_ready), 32'(model_ready()));
    check("stdout_wait", 32'(stdout_wait), 32'(m_host_owns));
    check("level", 32'(level), 32'(m_cnt));
    if (rd_chk) check("rd_data", 32'(rd_data), 32'(rd_exp));
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic handshake(input int hold);
    stdout_flushed = 1'b1;
    tick();
    check("hs_wait_drop", 32'(stdout_wait), 32'd0);
    check("hs_level_zero", 32'(level), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hs_ready_held", 32'(wr_ready), 32'd0);
    end
    stdout_flushed = 1'b0;
    tick();
    check("hs_ready_back", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pending;
    for (int i = 0; i < DEPTH; i++) begin m_known[i] = 0; m_mem[i] = 8'h00; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait", 32'(stdout_wait), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    tick();

    // Three bytes then flush
    write_byte(8'h41);
    write_byte(8'h42);
    write_byte(8'h43);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_wait", 32'(stdout_wait), 32'd1);
    check("flush_level", 32'(level), 32'd3);
    check("flush_ready", 32'(wr_ready), 32'd0);
    for (int a = 0; a < 3; a++) begin
      logic [7:0] exp_b;
      exp_b = 8'h41 + 8'(a);
      rd_addr = AW'(a);
      tick();
      check("read_abc", 32'(rd_data), 32'(exp_b));
    end
    handshake(5);

    // Full buffer, then a stalled 65th write
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    check("full_wait", 32'(stdout_wait), 32'd1);
    check("full_level", 32'(level), 32'(DEPTH));
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    repeat (3) begin
      tick();
      check("stall_ready", 32'(wr_ready), 32'd0);
    end
    stdout_flushed = 1'b1;
    repeat (2) tick();
    stdout_flushed = 1'b0;
    tick();
    tick();
    wr_valid = 1'b0;
    check("stalled_lands_level", 32'(level), 32'd1);
    rd_addr = '0;
    tick();
    check("stalled_lands_addr0", 32'(rd_data), 32'hA5);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    handshake(1);

    // Flush on empty is ignored; write+flush in same cycle
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("empty_flush_wait", 32'(stdout_wait), 32'd0);
    tick();
    check("empty_flush_not_remembered", 32'(stdout_wait), 32'd0);
    wr_valid  = 1'b1;
    wr_data   = 8'h5A;
    flush_req = 1'b1;
    tick();
    wr_valid  = 1'b0;
    flush_req = 1'b0;
    check("wrflush_level", 32'(level), 32'd1);
    check("wrflush_wait", 32'(stdout_wait), 32'd1);
    handshake(2);

    // Stale acknowledge in FILL is ignored
    stdout_flushed = 1'b1;
    repeat (2) tick();
    stdout_flushed = 1'b0;
    write_byte(8'h30);
    check("stale_ack_level", 32'(level), 32'd1);

    // Asynchronous reset while in WAIT with 10 bytes
    for (int i = 0; i < 9; i++) write_byte(8'h60 + 8'(i));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("pre_rst_level", 32'(level), 32'd10);
    rst = 1'b1;
    #1;
    check("async_rst_wait", 32'(stdout_wait), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_ready", 32'(wr_ready), 32'd1);
    m_cnt = 0; m_host_owns = 0; m_ack_pending = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    write_byte(8'h31);
    check("post_rst_level", 32'(level), 32'd1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    handshake(0);

    // "hi\n": line-buffered only when the macro is defined
    write_byte(8'h68);
    write_byte(8'h69);
    write_byte(8'h0A);
    check("nl_level", 32'(level), 32'd3);
`ifdef PULPEMU_STDOUT_NEWLINE_FLUSH_EN
    check("nl_wait", 32'(stdout_wait), 32'd1);
`else
    check("nl_wait", 32'(stdout_wait), 32'd0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
`endif
    handshake(0);

    // Randomized traffic with a host that acknowledges at random times
    pending = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pending && !model_ready()) begin
        // hold stalled write
      end else if ($urandom_range(0, 99) < 60) begin
        wr_valid = 1'b1;
        wr_data  = ($urandom_range(0, 15) == 0) ? 8'h0A : 8'($urandom);
        pending  = 1;
      end else begin
        wr_valid = 1'b0;
        pending  = 0;
      end
      flush_req = ($urandom_range(0, 99) < 4);
      if (m_host_owns)
        stdout_flushed = stdout_flushed || ($urandom_range(0, 3) == 0);
      else if (stdout_flushed)
        stdout_flushed = ($urandom_range(0, 2) != 0);
      else
        stdout_flushed = ($urandom_range(0, 99) < 2);
      rd_addr = AW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulpemu_stdout_buffer.md
Name: pulpemu_stdout_buffer

Overview:
- Character buffer between the PULP SoC stdout path and the Zynq host.
- Collects bytes written by PULP software into a local RAM.
- When the buffer fills, or PULP requests a flush, it raises `stdout_wait` toward the Zynq GPIO stage and holds writers off.
- The host reads the buffer through a simple read port, then pulses the 4-phase `stdout_flushed` handshake to release it.

Parameters:
- DEPTH, 64, buffer size in bytes; power of 2, at least 2.
- AW, $clog2(DEPTH), address width; localparam derived from DEPTH, not overridable.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- wr_valid_i  input  1  PULP byte-write request.
- wr_data_i  input  8  byte to store.
- wr_ready_o  output  1  write accepted when wr_valid_i && wr_ready_o.
- flush_req_i  input  1  single-cycle request to hand the buffer to the host.
- stdout_wait_o  output  1  buffer ready for host read; goes to the GPIO stage.
- stdout_flushed_i  input  1  host acknowledge, level, already synchronous to clk.
- rd_addr_i  input  AW  host read address.
- rd_data_o  output  8  registered read data.
- level_o  output  AW+1  number of valid bytes, 0..DEPTH.

Behaviour:
- Reset:
  - state=FILL, count=0.
  - stdout_wait_o=0, wr_ready_o=1 (combinational from state), rd_data_o=0.
  - RAM contents are not reset.
  - Reset asserted in any state aborts the handshake immediately; the host sees stdout_wait_o drop.
- Storage: write pointer equals count.
  - An accepted write stores mem[count[AW-1:0]] <= wr_data_i and increments count.
- level_o = count, registered.
- Read port:
  - rd_data_o <= mem[rd_addr_i] every cycle; 1-cycle latency.
  - Readable in any state.
  - Addresses at or above level_o return stale contents, which is legal.
- FSM states: FILL, WAIT, RELEASE.
  - FILL: wr_ready_o=1, stdout_wait_o=0.
    - Go to WAIT when an accepted write makes count==DEPTH.
    - Go to WAIT when flush_req_i=1 and the post-write count is >0.
    - flush_req_i with count 0 and no write is ignored; it is not remembered.
    - Write and flush in the same cycle: the byte is stored first, then WAIT with the new count.
  - WAIT: wr_ready_o=0, stdout_wait_o=1 (registered; asserts the cycle after entry).
    - count is frozen.
    - flush_req_i is ignored.
    - When stdout_flushed_i=1: go to RELEASE, set count=0, stdout_wait_o=0.
  - RELEASE: wr_ready_o=0, stdout_wait_o=0.
    - Wait for stdout_flushed_i=0, then go to FILL.
    - Prevents a stale acknowledge from releasing the next batch.
  - stdout_flushed_i=1 while in FILL is ignored.
- Writes are never dropped. A writer stalled by wr_ready_o=0 must hold wr_valid_i and wr_data_i.
- Count never exceeds DEPTH. In FILL at count==DEPTH the FSM is unreachable, because FILL always moves to WAIT on the write that fills the buffer.

Optional Feature:
- Macro: PULPEMU_STDOUT_NEWLINE_FLUSH_EN.
- Defined: an accepted write of 0x0A in FILL is stored, then the block goes to WAIT exactly as for flush_req_i (line-buffered stdout).
- Undefined: 0x0A is an ordinary byte; only full buffer or flush_req_i trigger WAIT.

Test Plan:
- Write 0x41,0x42,0x43 then pulse flush_req_i:
  - stdout_wait_o=1 next cycle, level_o=3, wr_ready_o=0.
  - Reading addresses 0..2 gives 0x41,0x42,0x43 one cycle after each address.
- Write DEPTH=64 bytes back-to-back:
  - WAIT is entered after the 64th write, level_o=64.
  - A 65th write stalls with wr_ready_o=0 until the handshake completes, then lands at address 0 with level_o=1.
- Handshake:
  - In WAIT, set stdout_flushed_i=1: stdout_wait_o=0 and level_o=0 the next cycle.
  - Hold stdout_flushed_i=1 for 5 cycles: wr_ready_o stays 0.
  - Drop stdout_flushed_i: wr_ready_o=1 the next cycle.
- flush_req_i with level_o=0: no state change, stdout_wait_o stays 0. Write and flush in the same cycle: level_o=1, WAIT entered.
- Assert rst while in WAIT with level_o=10: stdout_wait_o=0, level_o=0, wr_ready_o=1 immediately; normal fill resumes after release.
- With PULPEMU_STDOUT_NEWLINE_FLUSH_EN: writing "hi\n" gives WAIT with level_o=3. Without the macro: no WAIT, level_o=3.
